// File: rtl/ps2_pkg.sv
// Shared types and PS/2 command/response codes for the host-side PS/2 blocks.
package ps2_pkg;

    // Host transmitter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5
    } ps2_tx_state_t;

    // Keyboard commands sent by the host.
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Device responses, seen on the receive path.
    localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESP_RESEND = 8'hFE;

    // Falls counted from RTS exit: 1 = bit0, 9 = parity, 10 = stop, 11 = ACK.
    localparam logic [3:0] PS2_FALL_STOP = 4'd10;

    // PS/2 uses odd parity over data + parity bit.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser for the PS/2 clock and data lines plus a falling-edge strobe on
// the synchronised clock. Shared by the host transmit and receive paths.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clk_async,
    input  logic i_data_async,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fall
);

    logic [SYNC_STAGES-1:0] r_clk_pipe;
    logic [SYNC_STAGES-1:0] r_data_pipe;
    logic                   r_clk_prev;

    // Shift the raw line levels through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the chain resets to 1, the released-line level, so leaving
            // reset never looks like a clock fall.
            r_clk_pipe  <= '1;
            r_data_pipe <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage take the previous
            // stage's old value on the same edge; blocking would collapse the chain.
            r_clk_pipe  <= {r_clk_pipe[SYNC_STAGES-2:0], i_clk_async};
            r_data_pipe <= {r_data_pipe[SYNC_STAGES-2:0], i_data_async};
            r_clk_prev  <= r_clk_pipe[SYNC_STAGES-1];
        end
    end

    assign o_clk_sync  = r_clk_pipe[SYNC_STAGES-1];
    assign o_data_sync = r_data_pipe[SYNC_STAGES-1];
    assign o_clk_fall  = r_clk_prev & ~o_clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts one command byte out on device clock falls, then checks the device ACK.
// Line drive is through active-high pull-low enables; pads live at top level.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int               CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    ps2_tx_state_t    r_state;
    logic [9:0]       r_shift;      // {stop, parity, d7..d0}, bit0 on the line
    logic [3:0]       r_bit_cnt;    // clock falls since RTS exit
    logic [CNT_W-1:0] r_cnt;        // inhibit length, then frame timeout

    ps2_tx_state_t    w_state_nxt;
    logic [9:0]       w_shift_nxt;
    logic [3:0]       w_bit_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_oe;
    logic             w_data_oe;
    logic             w_done;
    logic             w_err;
    logic             w_timed;

    logic             w_clk_sync;
    logic             w_data_sync;
    logic             w_clk_fall;

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk          (clk),
        .reset        (reset),
        .i_clk_async  (ps2_clk_in),
        .i_data_async (ps2_data_in),
        .o_clk_sync   (w_clk_sync),
        .o_data_sync  (w_data_sync),
        .o_clk_fall   (w_clk_fall)
    );

    // State, shift register and counters; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state, counter updates and line/strobe outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cnt_nxt     = r_cnt;
        w_clk_oe      = 1'b0;
        w_data_oe     = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_timed       = r_state inside {ST_RTS, ST_SHIFT, ST_ACK};

        unique case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_shift_nxt   = {1'b1, ps2_odd_parity(tx_data), tx_data};
                    w_bit_cnt_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                w_clk_oe = 1'b1;
                if (r_cnt == INHIBIT_LAST) begin
                    // Start bit goes down while the clock is still held.
                    w_data_oe   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RTS;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RTS: begin
                w_data_oe = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_state_nxt   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                w_data_oe = ~r_shift[0];
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_clk_fall) begin
                    w_shift_nxt   = {1'b1, r_shift[9:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (w_bit_cnt_nxt == PS2_FALL_STOP) begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (!w_data_sync) begin
                        w_state_nxt = ST_WAIT_REL;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_WAIT_REL: begin
                // Not timed: the device owns the lines until it lets go.
                if (w_clk_sync && w_data_sync) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Timeout wins over any clock fall seen in the same cycle.
        if (w_timed && (r_cnt == TIMEOUT_LIMIT)) begin
            w_state_nxt   = ST_IDLE;
            w_shift_nxt   = r_shift;
            w_bit_cnt_nxt = r_bit_cnt;
            w_cnt_nxt     = '0;
            w_clk_oe      = 1'b0;
            w_data_oe     = 1'b0;
            w_err         = 1'b1;
        end
    end

    assign tx_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = w_done;
    assign err         = w_err;
    assign ps2_clk_oe  = w_clk_oe;
    assign ps2_data_oe = w_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the lines.
// One bench clock cycle stands for 1 us, so the device's 80-cycle clock period
// is 80 us and the 50_000-cycle timeout is far beyond a normal frame.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 100;
    localparam int TIMEOUT = 50_000;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    // Device-side drive of the open-drain lines (1 = released).
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       w_clk_line;
    logic       w_data_line;

    assign w_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign w_data_line = dev_data & ~ps2_data_oe;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int err_seen  = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ps2_clk_in  (w_clk_line),
        .ps2_data_in (w_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Count cycles in which done/err are high; a stuck strobe shows as > 1.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle (or leave it held when hold is set).
    task automatic send_req(input string tag, input logic [7:0] b, input logic hold);
        @(negedge clk);
        check({tag, "_ready_before"}, tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Measure the clock-inhibit phase; returns at the first RTS cycle.
    task automatic inhibit_phase(input string tag);
        int   n;
        logic last_doe;
        n        = 0;
        last_doe = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < 4 * INHIBIT) begin
            last_doe = ps2_data_oe;
            n++;
            @(negedge clk);
        end
        check({tag, "_inhibit_len"}, n, INHIBIT);
        check({tag, "_start_at_inhibit_end"}, last_doe, 1);
        check({tag, "_rts_data_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Keyboard: n_pulses clock pulses, samples data on each rising edge,
    // optionally pulls data low across pulse 11 as the ACK, then releases.
    task automatic dev_frame(input int n_pulses, input logic ack_low,
                             output logic [9:0] seen, output logic start_seen);
        seen = '1;
        repeat (HALF) @(negedge clk);
        start_seen = w_data_line;
        for (int k = 1; k <= n_pulses; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) seen[k-1] = w_data_line;
            repeat (HALF / 2) @(negedge clk);
            if (k == 10 && ack_low && n_pulses >= 11) dev_data = 1'b0;
            repeat (HALF - HALF / 2) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    initial begin
        logic [9:0] seen;
        logic       start_seen;
        int         d0;
        int         e0;
        int         n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: set-LEDs command, full frame with ACK.
        d0 = done_seen; e0 = err_seen;
        send_req("t1", PS2_CMD_SET_LEDS, 1'b0);
        inhibit_phase("t1");
        check("t1_busy", {busy, tx_ready}, 2'b10);
        dev_frame(11, 1'b1, seen, start_seen);
        check("t1_start_bit", start_seen, 0);
        check("t1_bits", seen, 10'h3ED);
        repeat (10) @(negedge clk);
        check("t1_done_once", done_seen - d0, 1);
        check("t1_no_err", err_seen - e0, 0);
        check("t1_idle_after", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);

        // 2: enable (parity 0) then 8'h00 (parity 1).
        d0 = done_seen; e0 = err_seen;
        send_req("t2a", PS2_CMD_ENABLE, 1'b0);
        inhibit_phase("t2a");
        dev_frame(11, 1'b1, seen, start_seen);
        check("t2a_bits", seen, 10'h2F4);
        repeat (10) @(negedge clk);
        check("t2a_done_once", done_seen - d0, 1);
        d0 = done_seen;
        send_req("t2b", 8'h00, 1'b0);
        inhibit_phase("t2b");
        dev_frame(11, 1'b1, seen, start_seen);
        check("t2b_bits", seen, 10'h300);
        repeat (10) @(negedge clk);
        check("t2b_done_once", done_seen - d0, 1);
        check("t2_no_err", err_seen - e0, 0);

        // 3: device never clocks; timeout counted from the first RTS cycle.
        d0 = done_seen; e0 = err_seen;
        send_req("t3", PS2_CMD_RESET, 1'b0);
        inhibit_phase("t3");
        n = 0;
        while (err !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_timeout_cycles", n, TIMEOUT);
        check("t3_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("t3_ready_in_err_cycle", tx_ready, 0);
        @(negedge clk);
        check("t3_ready_next", tx_ready, 1);
        repeat (5) @(negedge clk);
        check("t3_err_once", err_seen - e0, 1);
        check("t3_no_done", done_seen - d0, 0);

        // 4: missing ACK, then a normal frame.
        d0 = done_seen; e0 = err_seen;
        send_req("t4", PS2_CMD_ECHO, 1'b0);
        inhibit_phase("t4");
        dev_frame(11, 1'b0, seen, start_seen);
        check("t4_bits", seen, 10'h3EE);
        repeat (10) @(negedge clk);
        check("t4_err_once", err_seen - e0, 1);
        check("t4_no_done", done_seen - d0, 0);
        d0 = done_seen; e0 = err_seen;
        send_req("t4b", PS2_CMD_RESET, 1'b0);
        inhibit_phase("t4b");
        dev_frame(11, 1'b1, seen, start_seen);
        check("t4b_bits", seen, 10'h3FF);
        repeat (10) @(negedge clk);
        check("t4b_done_once", done_seen - d0, 1);
        check("t4b_no_err", err_seen - e0, 0);

        // 5: tx_valid held and tx_data changed mid-frame.
        d0 = done_seen; e0 = err_seen;
        send_req("t5", PS2_CMD_ENABLE, 1'b1);
        tx_data = 8'h55;
        inhibit_phase("t5");
        check("t5_busy", {busy, tx_ready}, 2'b10);
        dev_frame(11, 1'b1, seen, start_seen);
        tx_valid = 1'b0;
        check("t5_bits", seen, 10'h2F4);
        repeat (10) @(negedge clk);
        check("t5_done_once", done_seen - d0, 1);
        check("t5_no_second_frame", {busy, ps2_clk_oe}, 2'b00);
        check("t5_no_err", err_seen - e0, 0);

        // 6: reset after 4 data bits, then a clean frame.
        d0 = done_seen; e0 = err_seen;
        send_req("t6", PS2_CMD_ENABLE, 1'b0);
        inhibit_phase("t6");
        dev_frame(4, 1'b0, seen, start_seen);
        check("t6_bits_before_abort", seen[3:0], 4'b0100);
        check("t6_driving_bit3", ps2_data_oe, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_oe_drop", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("t6_idle_in_reset", {tx_ready, busy}, 2'b10);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_done", done_seen - d0, 0);
        check("t6_no_err", err_seen - e0, 0);
        send_req("t6b", PS2_CMD_SET_LEDS, 1'b0);
        inhibit_phase("t6b");
        dev_frame(11, 1'b1, seen, start_seen);
        check("t6b_bits", seen, 10'h3ED);
        repeat (10) @(negedge clk);
        check("t6b_done_once", done_seen - d0, 1);
        check("t6b_no_err", err_seen - e0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
